// File: rtl/cla_sequencer.sv
// Multi-cycle wide adder/subtractor: one SLICE_WIDTH carry-look-ahead slice per RUN cycle,
// with the inter-slice carry held in a register and the result delivered over valid/ready.
module cla_sequencer #(
    parameter int DATA_WIDTH  = 32,
    parameter int SLICE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  cin,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  cout,
    output logic                  overflow
);
    localparam int NUM_SLICES = DATA_WIDTH / SLICE_WIDTH;
    localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);
    localparam logic [DATA_WIDTH-1:0] SLICE_MASK = DATA_WIDTH'({SLICE_WIDTH{1'b1}});

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    carry_q, carry_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [DATA_WIDTH-1:0]   acc_q, acc_d, sum_q, sum_d;
    logic                    cout_q, cout_d, ovf_q, ovf_d;

    logic [SLICE_WIDTH-1:0]  sa, sb, p, g, s_bits;
    logic                    cc, c_msb;
    int unsigned             base;

    // Carry-look-ahead slice for the current index; carry walked with a scalar to stay acyclic.
    always_comb begin
        base   = 32'(idx_q) * 32'(SLICE_WIDTH);
        sa     = SLICE_WIDTH'(a_q >> base);
        sb     = SLICE_WIDTH'(b_q >> base);
        p      = sa ^ sb;
        g      = sa & sb;
        s_bits = '0;
        c_msb  = 1'b0;
        cc     = carry_q;
        for (int i = 0; i < SLICE_WIDTH; i++) begin
            s_bits[i] = p[i] ^ cc;
            if (i == SLICE_WIDTH - 1) c_msb = cc;
            cc = g[i] | (p[i] & cc);
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d   = (acc_q & ~(SLICE_MASK << base)) | (DATA_WIDTH'(s_bits) << base);
                carry_d = cc;
                if (idx_q == LAST_IDX) begin
                    sum_d   = acc_d;
                    cout_d  = cc;
                    ovf_d   = c_msb ^ cc;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_cla_sequencer.sv
// Bench for cla_sequencer: an 8-bit-slice build and a single-slice build side by side,
// driven from a vector table, directed corner sequences and random operands.
module tb_cla_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        in_valid_v[2], in_ready_v[2], cin_v[2], sub_v[2];
    logic        out_valid_v[2], out_ready_v[2], cout_v[2], ovf_v[2];
    logic [31:0] a_v[2], b_v[2], sum_v[2];

    int n_pass = 0;
    int n_tot  = 0;
    int lat_exp[2] = '{4, 1};

    cla_sequencer #(.DATA_WIDTH(32), .SLICE_WIDTH(8)) u_narrow (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a_v[0]), .b(b_v[0]), .cin(cin_v[0]), .sub(sub_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .sum(sum_v[0]), .cout(cout_v[0]), .overflow(ovf_v[0]));

    cla_sequencer #(.DATA_WIDTH(32), .SLICE_WIDTH(32)) u_wide (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a_v[1]), .b(b_v[1]), .cin(cin_v[1]), .sub(sub_v[1]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .sum(sum_v[1]), .cout(cout_v[1]), .overflow(ovf_v[1]));

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] s;
        logic        co;
        logic        ov;
        int          hold;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    endtask

    // Reference: whole-word arithmetic. Returns {overflow, cout, sum}.
    function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic ci, input logic s);
        logic [31:0] ye;
        logic [32:0] r;
        logic        v;
        ye = s ? ~y : y;
        r  = {1'b0, x} + {1'b0, ye} + 33'(s ? 1'b1 : ci);
        v  = (x[31] == ye[31]) && (r[31] != x[31]);
        return {v, r};
    endfunction

    // Called at a negedge; returns at a negedge with the DUT back in IDLE.
    task automatic op(input int d, input logic [31:0] ta, input logic [31:0] tb_,
                      input logic tc, input logic ts, input logic [31:0] es,
                      input logic eco, input logic eov, input int hold);
        int n;
        int lat;
        n = 0;
        while (!in_ready_v[d] && n < 20) begin @(negedge clk); n++; end
        chk("accept_ready", 64'(in_ready_v[d]), 64'(1));
        a_v[d] = ta; b_v[d] = tb_; cin_v[d] = tc; sub_v[d] = ts;
        in_valid_v[d] = 1'b1; out_ready_v[d] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid_v[d] = 1'b0;
        a_v[d] = $urandom; b_v[d] = $urandom; cin_v[d] = 1'($urandom); sub_v[d] = 1'($urandom);
        lat = 0;
        while (!out_valid_v[d] && lat < 20) begin
            @(posedge clk); lat++;
            @(negedge clk);
        end
        chk("latency", 64'(lat), 64'(lat_exp[d]));
        chk("sum", 64'(sum_v[d]), 64'(es));
        chk("cout", 64'(cout_v[d]), 64'(eco));
        chk("overflow", 64'(ovf_v[d]), 64'(eov));
        chk("done_in_ready", 64'(in_ready_v[d]), 64'(0));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("bp_valid", 64'(out_valid_v[d]), 64'(1));
            chk("bp_in_ready", 64'(in_ready_v[d]), 64'(0));
            chk("bp_sum", 64'(sum_v[d]), 64'(es));
        end
        out_ready_v[d] = 1'b1;
        @(negedge clk);
        out_ready_v[d] = 1'b0;
        chk("post_valid", 64'(out_valid_v[d]), 64'(0));
        chk("post_ready", 64'(in_ready_v[d]), 64'(1));
        chk("post_sum_held", 64'(sum_v[d]), 64'(es));
    endtask

    task automatic rand_op(input int d, input int hold);
        logic [31:0] x, y;
        logic ci, s;
        logic [33:0] m;
        x = $urandom; y = $urandom;
        case ($urandom_range(5))
            0: x = 32'hFFFF_FFFF;
            1: y = 32'h8000_0000;
            2: y = x;
            default: ;
        endcase
        ci = 1'($urandom); s = 1'($urandom);
        m = model(x, y, ci, s);
        op(d, x, y, ci, s, m[31:0], m[32], m[33], hold);
    endtask

    initial begin
        tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 0};
        tbl[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 0};
        tbl[2] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 0};
        tbl[3] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 3};
        tbl[4] = '{32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 32'h0000_0007, 1'b0, 1'b0, 0};
        tbl[5] = '{32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1};
        tbl[6] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 0};
        tbl[7] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0, 0};

        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid_v[d] = 1'b0; out_ready_v[d] = 1'b0;
            a_v[d] = '0; b_v[d] = '0; cin_v[d] = 1'b0; sub_v[d] = 1'b0;
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("rst_in_ready", 64'(in_ready_v[d]), 64'(1));
            chk("rst_out_valid", 64'(out_valid_v[d]), 64'(0));
            chk("rst_sum", 64'(sum_v[d]), 64'(0));
            chk("rst_cout", 64'(cout_v[d]), 64'(0));
            chk("rst_ovf", 64'(ovf_v[d]), 64'(0));
        end

        // Table entries run back-to-back on both builds.
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 8; i++)
                op(d, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub,
                   tbl[i].s, tbl[i].co, tbl[i].ov, tbl[i].hold);

        // Single-slice build: both MSBs set.
        op(1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 0);

        // Reset two edges into RUN discards the operation.
        op(0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 0);
        a_v[0] = 32'hFFFF_FFFF; b_v[0] = 32'h1; cin_v[0] = 1'b0; sub_v[0] = 1'b0;
        in_valid_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk); in_valid_v[0] = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("mid_rst_in_ready", 64'(in_ready_v[0]), 64'(1));
        chk("mid_rst_out_valid", 64'(out_valid_v[0]), 64'(0));
        chk("mid_rst_sum", 64'(sum_v[0]), 64'(0));
        chk("mid_rst_cout", 64'(cout_v[0]), 64'(0));
        repeat (5) @(negedge clk);
        chk("mid_rst_no_output", 64'(out_valid_v[0]), 64'(0));
        op(0, 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 32'h7, 1'b0, 1'b0, 0);

        // A request held through the DONE handshake is taken only in the following IDLE cycle.
        a_v[0] = 32'h10; b_v[0] = 32'h20; cin_v[0] = 1'b0; sub_v[0] = 1'b0;
        in_valid_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        repeat (4) @(negedge clk);
        chk("hs_done", 64'(out_valid_v[0]), 64'(1));
        a_v[0] = 32'h1; b_v[0] = 32'h2;
        out_ready_v[0] = 1'b1;
        @(negedge clk);
        out_ready_v[0] = 1'b0;
        chk("hs_not_taken", 64'(in_ready_v[0]), 64'(1));
        chk("hs_sum", 64'(sum_v[0]), 64'h30);
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        chk("hs_taken", 64'(in_ready_v[0]), 64'(0));
        repeat (4) @(negedge clk);
        chk("hs_second_valid", 64'(out_valid_v[0]), 64'(1));
        chk("hs_second_sum", 64'(sum_v[0]), 64'h3);
        out_ready_v[0] = 1'b1;
        @(negedge clk);
        out_ready_v[0] = 1'b0;

        for (int i = 0; i < 30; i++) rand_op(0, int'($urandom_range(2)));
        for (int i = 0; i < 12; i++) rand_op(1, int'($urandom_range(2)));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
